ifetch_axi_rd_bridge: RTL

Responder end of the IF-stage instruction-fetch request interface. Accepts SRAM-like fetch requests (req/addr_ok/data_ok) from the fetch pipeline and turns them into AXI read transactions (single beat or two-beat INCR burst for dual-instruction fetch). It tracks up to DEPTH in-order outstanding fetches and silently discards the returned data of fetches killed by a pipeline flush. It sits between the IF/pre-IF stages and the AXI crossbar in mycpu_top.

---
 rtl/ifetch_axi_rd_bridge.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/ifetch_axi_rd_bridge.sv
// Instruction-fetch responder: turns SRAM-like fetch requests into in-order AXI reads
// (single beat or 2-beat INCR) and drops data of fetches killed by a pipeline flush.
`timescale 1ns/1ps
module ifetch_axi_rd_bridge #(
    parameter int         DEPTH    = 4,
    parameter logic [3:0] ARID_VAL = 4'd0
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        inst_req_i,
    input  logic [31:0] inst_addr_i,
    input  logic        inst_two_i,
    input  logic        inst_cancel_i,
    output logic        inst_addr_ok_o,
    output logic        inst_data_ok_o,
    output logic [31:0] inst_rdata1_o,
    output logic [31:0] inst_rdata2_o,
    output logic        inst_rdata2_en_o,
    output logic        inst_err_o,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam int             PW       = $clog2(DEPTH);
    localparam logic [PW:0]    FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW-1:0]  PTR_ONE  = PW'(1'b1);
    localparam logic [PW:0]    CNT_ONE  = (PW+1)'(1'b1);

    typedef enum logic {AR_IDLE = 1'b0, AR_WAIT = 1'b1} ar_state_t;
    typedef enum logic {R_FIRST = 1'b0, R_SECOND = 1'b1} r_state_t;

    ar_state_t          ar_state_r;
    r_state_t           r_state_r;

    logic [DEPTH-1:0]   fifo_two_r;
    logic [DEPTH-1:0]   fifo_disc_r;
    logic [PW-1:0]      wr_ptr_r;
    logic [PW-1:0]      rd_ptr_r;
    logic [PW:0]        count_r;

    logic [31:0]        buf1_r;
    logic               err_acc_r;

    logic               accept_s;
    logic               two_eff_s;
    logic               beat_s;
    logic               head_two_s;
    logic               head_disc_s;
    logic               complete_s;
    logic               deliver_s;
    logic               rresp_err_s;
    logic               unused_s;

    assign arid    = ARID_VAL;
    assign arsize  = 3'd2;
    assign arburst = 2'b01;

    // rid/rlast carry no information here: responses are in order and beat count comes from the FIFO
    assign unused_s = ^{rid, rlast};

    // Request acceptance, beat qualification and completion decode
    always_comb begin
        two_eff_s   = inst_two_i & ~inst_addr_i[2];
        accept_s    = inst_req_i & (count_r != FULL_CNT) & (~arvalid | arready);
        head_two_s  = fifo_two_r[rd_ptr_r];
        head_disc_s = fifo_disc_r[rd_ptr_r];
        beat_s      = rvalid & rready & (count_r != {(PW+1){1'b0}});
        complete_s  = beat_s & ((r_state_r == R_SECOND) | ~head_two_s);
        deliver_s   = complete_s & ~head_disc_s & ~inst_cancel_i;
        rresp_err_s = (rresp != 2'b00);
    end

    assign inst_addr_ok_o = accept_s;

    // AR channel FSM: a new accept may reload the address registers while the previous AR handshakes
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ar_state_r <= AR_IDLE;
            arvalid    <= 1'b0;
            araddr     <= 32'd0;
            arlen      <= 8'd0;
        end else begin
            case (ar_state_r)
                AR_IDLE: begin
                    if (accept_s) begin
                        araddr     <= inst_addr_i;
                        arlen      <= {7'd0, two_eff_s};
                        arvalid    <= 1'b1;
                        ar_state_r <= AR_WAIT;
                    end
                end
                AR_WAIT: begin
                    if (accept_s) begin
                        araddr <= inst_addr_i;
                        arlen  <= {7'd0, two_eff_s};
                    end else if (arready) begin
                        arvalid    <= 1'b0;
                        ar_state_r <= AR_IDLE;
                    end
                end
                default: begin
                    arvalid    <= 1'b0;
                    ar_state_r <= AR_IDLE;
                end
            endcase
        end
    end

    // Tracking FIFO of {two, discard}; a flush marks everything in flight, including this cycle's push
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            fifo_two_r  <= {DEPTH{1'b0}};
            fifo_disc_r <= {DEPTH{1'b0}};
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {(PW+1){1'b0}};
        end else begin
            if (inst_cancel_i) begin
                fifo_disc_r <= {DEPTH{1'b1}};
            end
            if (accept_s) begin
                fifo_two_r[wr_ptr_r]  <= two_eff_s;
                fifo_disc_r[wr_ptr_r] <= inst_cancel_i;
                wr_ptr_r              <= wr_ptr_r + PTR_ONE;
            end
            if (complete_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({accept_s, complete_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // R channel FSM plus registered fetch-return outputs
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_r        <= R_FIRST;
            buf1_r           <= 32'd0;
            err_acc_r        <= 1'b0;
            rready           <= 1'b0;
            inst_data_ok_o   <= 1'b0;
            inst_rdata1_o    <= 32'd0;
            inst_rdata2_o    <= 32'd0;
            inst_rdata2_en_o <= 1'b0;
            inst_err_o       <= 1'b0;
        end else begin
            rready         <= 1'b1;
            inst_data_ok_o <= deliver_s;
            if (deliver_s) begin
                inst_rdata1_o    <= (r_state_r == R_SECOND) ? buf1_r : rdata;
                inst_rdata2_o    <= (r_state_r == R_SECOND) ? rdata : 32'd0;
                inst_rdata2_en_o <= head_two_s;
                inst_err_o       <= err_acc_r | rresp_err_s;
            end
            if (beat_s) begin
                case (r_state_r)
                    R_FIRST: begin
                        buf1_r <= rdata;
                        if (head_two_s) begin
                            err_acc_r <= err_acc_r | rresp_err_s;
                            r_state_r <= R_SECOND;
                        end else begin
                            err_acc_r <= 1'b0;
                        end
                    end
                    R_SECOND: begin
                        err_acc_r <= 1'b0;
                        r_state_r <= R_FIRST;
                    end
                    default: begin
                        err_acc_r <= 1'b0;
                        r_state_r <= R_FIRST;
                    end
                endcase
            end
        end
    end

endmodule
